alu_writeback_stage: RTL and testbench
======================================

Name: alu_writeback_stage

Overview:
- Sits directly downstream of the 32-bit alu. Captures Output plus the CarryOut/zero/overflow/negative flags each time an operation is accepted.
- Holds the architectural NZCV status register and buffers up to DEPTH pending register-file writes behind a valid/ready handshake.
- Decouples ALU issue from register-file write-port stalls and counts signed-overflow events for debug.

Parameters:
- WIDTH, 32, datapath width (matches alu buses)
- ADDR_W, 5, register-file address width
- DEPTH, 2, write-buffer entries (power of two, >=2)
- ZERO_REG, 31, destination index whose writes are discarded
- CNT_W, 16, overflow event counter width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  ALU result valid this cycle
- in_ready  out  1  stage can accept a result
- alu_result  in  WIDTH  alu Output
- alu_carry  in  1  alu CarryOut
- alu_zero  in  1  alu zero
- alu_overflow  in  1  alu overflow
- alu_negative  in  1  alu negative
- alu_op  in  2  ALUControl used for this result
- dest_reg  in  ADDR_W  destination register
- reg_write  in  1  result is to be written back
- set_flags  in  1  result updates NZCV
- wb_valid  out  1  write request to register file
- wb_ready  in  1  register file accepts write
- wb_data  out  WIDTH  write data
- wb_addr  out  ADDR_W  write address
- flags  out  4  {N,Z,C,V} status register
- ovf_count  out  CNT_W  saturating count of overflow events

Behaviour:
- Reset (synchronous, sampled on rising clk):
  - FIFO emptied; wb_valid=0, wb_data=0, wb_addr=0.
  - flags=4'b0000, ovf_count=0.
  - in_ready=0 during any cycle where reset is high; in_ready=1 from the first cycle after reset deasserts.
  - Reset mid-operation discards all buffered writes; nothing partially drains.
- Accept = in_valid && in_ready at a rising edge. in_ready = (count < DEPTH), computed from registered count only. A full buffer does not accept even while a dequeue occurs that same cycle; this is the required behaviour, not a bypass.
- Enqueue: on accept, entry {alu_result, dest_reg} is pushed only if reg_write=1 and dest_reg != ZERO_REG. Otherwise the op is accepted but not buffered (compare-style or zero-register op).
- Flags, updated at the accept edge, independent of wb stall:
  - set_flags=1, alu_op in {00 add, 01 sub}: flags <= {alu_negative, alu_zero, alu_carry, alu_overflow}.
  - set_flags=1, alu_op in {10, 11} (logical): N and Z updated; C and V retain prior values.
  - set_flags=0: flags unchanged.
- ovf_count increments on accept when alu_op is 00/01 and alu_overflow=1, regardless of set_flags. Saturates at all-ones; no wrap.
- Dequeue = wb_valid && wb_ready. wb_data/wb_addr present the head entry and stay stable while wb_valid=1 && wb_ready=0.
- Latency: a result accepted at edge N into an empty buffer gives wb_valid=1 in the cycle after edge N. The flags update is also visible after edge N.
- Simultaneous enqueue and dequeue with count in 1..DEPTH-1: count unchanged, order preserved (strict FIFO).
- Pointers wrap modulo DEPTH. count is ADDR-independent, with width clog2(DEPTH)+1.
- No output is combinationally dependent on in_valid or wb_ready.

Decomposition:
- Shared package alu_pkg:
  - alu_op_t enum (ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_OR=2'b11).
  - flags_t packed struct {n,z,c,v}.
  - wb_entry_t struct {data, addr}.
- One sub-module: wb_fifo (parameterised DEPTH-entry synchronous FIFO carrying wb_entry_t, with full/empty/count). Flag and counter logic stays in the top.

Test Plan:
- Add overflow: reset, then alu_op=00, alu_result=32'h80000000, negative=1, overflow=1, carry=0, zero=0, set_flags=1, reg_write=1, dest_reg=3, wb_ready=1 -> next cycle wb_valid=1, wb_data=32'h80000000, wb_addr=3; flags=4'b1001; ovf_count=1.
- Backpressure: wb_ready=0, three back-to-back accepts of 32'h000018AB, 32'h00001339, 32'h00000333 -> in_ready drops after the 2nd; the 3rd is held. Raise wb_ready -> writes drain in order 18AB, 1339, then 0333 accepted and written.
- Logical op flags: after flags=4'b0011, issue alu_op=10, result 0, zero=1, set_flags=1 -> flags=4'b0111 (C,V retained).
- Compare/zero-reg: sub 32'h00001234-32'h00001234 with reg_write=0, and a write to dest_reg=31 -> no wb_valid for either; flags Z=1 after the compare.
- Saturation: force 2^CNT_W+3 overflow accepts -> ovf_count stays 16'hFFFF.
- Reset mid-drain: two entries buffered, wb_ready=0, assert reset one cycle -> wb_valid=0, flags=0, ovf_count=0, in_ready=0 during reset and 1 after. The buffered writes never appear.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU writeback types: op encoding, NZCV flags, buffered write entry.
package alu_pkg;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_OR  = 2'b11
   } alu_op_t;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } flags_t;

   localparam int DATA_W = 32;
   localparam int REG_W  = 5;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [REG_W-1:0]  addr;
   } wb_entry_t;

   function automatic logic is_arith(alu_op_t op);
      return (op == ALU_ADD) || (op == ALU_SUB);
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// DEPTH-entry synchronous FIFO for pending register-file writes.
module wb_fifo
   import alu_pkg::*;
#(
   parameter int  DEPTH   = 2,
   parameter type entry_t = wb_entry_t
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  entry_t                     din,
   input  logic                       pop,
   output entry_t                     dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   entry_t          mem_q [DEPTH];
   entry_t          mem_d [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            push_ok, pop_ok;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign count   = count_q;
   assign dout    = mem_q[rd_ptr_q];
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   // Pointers are exactly log2(DEPTH) bits wide, so they wrap for free.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/alu_writeback_stage.sv
// ALU writeback: NZCV status register, overflow counter and buffered
// register-file writes behind valid/ready handshakes on both sides.
module alu_writeback_stage
   import alu_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int ADDR_W   = 5,
   parameter int DEPTH    = 2,
   parameter int ZERO_REG = 31,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  alu_result,
   input  logic              alu_carry,
   input  logic              alu_zero,
   input  logic              alu_overflow,
   input  logic              alu_negative,
   input  logic [1:0]        alu_op,
   input  logic [ADDR_W-1:0] dest_reg,
   input  logic              reg_write,
   input  logic              set_flags,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [WIDTH-1:0]  wb_data,
   output logic [ADDR_W-1:0] wb_addr,
   output logic [3:0]        flags,
   output logic [CNT_W-1:0]  ovf_count
);

   localparam int CW = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [WIDTH-1:0]  data;
      logic [ADDR_W-1:0] addr;
   } entry_t;

   alu_op_t          op;
   logic             accept, push, pop;
   logic             full, empty;
   logic [CW-1:0]    count;
   entry_t           din, head;
   flags_t           flags_q, flags_d;
   logic [CNT_W-1:0] ovf_count_q, ovf_count_d;

   assign op       = alu_op_t'(alu_op);
   // Registered occupancy only: a full buffer refuses even while draining.
   assign in_ready = !reset && (count < CW'(DEPTH));
   assign accept   = in_valid && in_ready;
   assign push     = accept && reg_write && !full
                     && (dest_reg != ADDR_W'(ZERO_REG));
   assign din      = '{data: alu_result, addr: dest_reg};
   assign wb_valid = !empty;
   assign pop      = wb_valid && wb_ready;
   assign wb_data  = wb_valid ? head.data : '0;
   assign wb_addr  = wb_valid ? head.addr : '0;

   wb_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (din),
      .pop   (pop),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   // Logical ops leave C and V holding the last arithmetic result.
   always_comb begin
      flags_d = flags_q;
      if (accept && set_flags) begin
         flags_d.n = alu_negative;
         flags_d.z = alu_zero;
         if (is_arith(op)) begin
            flags_d.c = alu_carry;
            flags_d.v = alu_overflow;
         end
      end
   end

   always_comb begin
      ovf_count_d = ovf_count_q;
      if (accept && is_arith(op) && alu_overflow
          && (ovf_count_q != {CNT_W{1'b1}})) begin
         ovf_count_d = ovf_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         flags_q     <= '0;
         ovf_count_q <= '0;
      end else begin
         flags_q     <= flags_d;
         ovf_count_q <= ovf_count_d;
      end
   end

   assign flags     = flags_q;
   assign ovf_count = ovf_count_q;

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Bench for alu_writeback_stage: vector table plus write scoreboard.
module tb_alu_writeback_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] alu_result = '0;
   logic        alu_carry = 1'b0;
   logic        alu_zero = 1'b0;
   logic        alu_overflow = 1'b0;
   logic        alu_negative = 1'b0;
   logic [1:0]  alu_op = '0;
   logic [4:0]  dest_reg = '0;
   logic        reg_write = 1'b0;
   logic        set_flags = 1'b0;
   logic        wb_valid;
   logic        wb_ready = 1'b0;
   logic [31:0] wb_data;
   logic [4:0]  wb_addr;
   logic [3:0]  flags;
   logic [15:0] ovf_count;

   always #5 clk = ~clk;

   alu_writeback_stage dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .alu_result   (alu_result),
      .alu_carry    (alu_carry),
      .alu_zero     (alu_zero),
      .alu_overflow (alu_overflow),
      .alu_negative (alu_negative),
      .alu_op       (alu_op),
      .dest_reg     (dest_reg),
      .reg_write    (reg_write),
      .set_flags    (set_flags),
      .wb_valid     (wb_valid),
      .wb_ready     (wb_ready),
      .wb_data      (wb_data),
      .wb_addr      (wb_addr),
      .flags        (flags),
      .ovf_count    (ovf_count)
   );

   typedef struct {
      logic [1:0]  op;
      logic [31:0] res;
      logic        n, z, c, v, sf, rw;
      logic [4:0]  dest;
      logic [3:0]  eflags;
      logic [15:0] eovf;
      logic        ewbv;
   } vec_t;

   typedef struct {
      logic [31:0] d;
      logic [4:0]  a;
   } wr_t;

   wr_t         sb[$];
   vec_t        tbl[11];
   int          checks = 0;
   int          errors = 0;
   logic        held_v = 1'b0;
   logic [36:0] held = '0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (held_v && wb_valid)
            chk("wb_stable", 64'({wb_data, wb_addr}), 64'(held));
         if (wb_valid && wb_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL wb_unexpected: got %0h@%0d, expected none",
                        wb_data, wb_addr);
            end else begin
               chk("wb_data", 64'(wb_data), 64'(sb[0].d));
               chk("wb_addr", 64'(wb_addr), 64'(sb[0].a));
               sb.delete(0);
            end
         end
         held_v = wb_valid && !wb_ready;
         held   = {wb_data, wb_addr};
      end else begin
         held_v = 1'b0;
      end
   end

   task automatic send(input vec_t v);
      int n = 0;
      in_valid     = 1'b1;
      alu_op       = v.op;
      alu_result   = v.res;
      alu_negative = v.n;
      alu_zero     = v.z;
      alu_carry    = v.c;
      alu_overflow = v.v;
      set_flags    = v.sf;
      reg_write    = v.rw;
      dest_reg     = v.dest;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got in_ready=0, expected 1");
      end else if (v.rw && v.dest != 5'd31) begin
         sb.push_back('{v.res, v.dest});
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("rst_in_ready_hi", 64'(in_ready), 64'(0));
      @(posedge clk);
      #1;
      reset = 1'b0;
      sb.delete();
      @(negedge clk);
      chk("rst_in_ready_lo", 64'(in_ready), 64'(1));
      chk("rst_wb_valid", 64'(wb_valid), 64'(0));
      chk("rst_wb_data", 64'(wb_data), 64'(0));
      chk("rst_wb_addr", 64'(wb_addr), 64'(0));
      chk("rst_flags", 64'(flags), 64'(0));
      chk("rst_ovf", 64'(ovf_count), 64'(0));
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      chk("drain_left", 64'(sb.size()), 64'(0));
   endtask

   vec_t va, vb, vc;

   initial begin
      //         op     result        n     z     c     v     sf    rw    dest   flags    ovf     wbv
      tbl[0]  = '{2'b00, 32'h80000000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd3,  4'b1001, 16'd1, 1'b1};
      tbl[1]  = '{2'b01, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4,  4'b0110, 16'd1, 1'b1};
      tbl[2]  = '{2'b10, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd5,  4'b0110, 16'd1, 1'b1};
      tbl[3]  = '{2'b00, 32'h00000001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd6,  4'b0110, 16'd2, 1'b1};
      tbl[4]  = '{2'b00, 32'h00000005, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd7,  4'b0011, 16'd3, 1'b1};
      tbl[5]  = '{2'b11, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8,  4'b0111, 16'd3, 1'b1};
      tbl[6]  = '{2'b11, 32'hF0000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9,  4'b1011, 16'd3, 1'b1};
      tbl[7]  = '{2'b01, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd10, 4'b0110, 16'd3, 1'b0};
      tbl[8]  = '{2'b00, 32'h00000055, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd31, 4'b0110, 16'd3, 1'b0};
      tbl[9]  = '{2'b01, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd30, 4'b0110, 16'd4, 1'b1};
      tbl[10] = '{2'b10, 32'h00000012, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0,  4'b0010, 16'd4, 1'b1};

      do_reset();
      wb_ready = 1'b1;
      for (int i = 0; i < 11; i++) begin
         send(tbl[i]);
         @(negedge clk);
         chk($sformatf("vec%0d_flags", i), 64'(flags), 64'(tbl[i].eflags));
         chk($sformatf("vec%0d_ovf", i), 64'(ovf_count), 64'(tbl[i].eovf));
         chk($sformatf("vec%0d_wbv", i), 64'(wb_valid), 64'(tbl[i].ewbv));
         @(posedge clk);
         #1;
      end
      drain();

      // Backpressure: two entries fill the buffer, the third waits.
      do_reset();
      wb_ready = 1'b0;
      va = '{2'b00, 32'h000018AB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 4'b0, 16'd0, 1'b1};
      vb = '{2'b00, 32'h00001339, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 4'b0, 16'd0, 1'b1};
      vc = '{2'b00, 32'h00000333, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 4'b0, 16'd0, 1'b1};
      send(va);
      send(vb);
      fork
         send(vc);
         begin
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               chk("bp_in_ready", 64'(in_ready), 64'(0));
               chk("bp_wb_valid", 64'(wb_valid), 64'(1));
               chk("bp_head", 64'(wb_data), 64'(32'h000018AB));
            end
            @(posedge clk);
            #1;
            wb_ready = 1'b1;
         end
      join
      drain();

      // Overflow counter saturation.
      do_reset();
      wb_ready     = 1'b1;
      alu_op       = 2'b00;
      alu_overflow = 1'b1;
      reg_write    = 1'b0;
      set_flags    = 1'b0;
      in_valid     = 1'b1;
      repeat (65534) @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("sat_pre", 64'(ovf_count), 64'(16'hFFFE));
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("sat_hold", 64'(ovf_count), 64'(16'hFFFF));
      chk("sat_flags", 64'(flags), 64'(0));
      @(posedge clk);
      #1;

      // Reset while two writes are stalled in the buffer.
      do_reset();
      wb_ready = 1'b0;
      va = '{2'b00, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd12, 4'b0, 16'd0, 1'b1};
      vb = '{2'b01, 32'h00000002, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd13, 4'b0, 16'd0, 1'b1};
      send(va);
      send(vb);
      @(negedge clk);
      chk("mid_flags", 64'(flags), 64'(4'b0011));
      chk("mid_ovf", 64'(ovf_count), 64'(2));
      chk("mid_wb_valid", 64'(wb_valid), 64'(1));
      @(posedge clk);
      #1;
      do_reset();
      wb_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("post_rst_wbv", 64'(wb_valid), 64'(0));
      end
      chk("end_sb_empty", 64'(sb.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
